fuzz_stim_sequencer: RTL

Synthesizable stimulus controller that sequences a fuzz DUT (flat `in_flat`/`out_flat` interface) without a behavioural testbench.
- On `start`: holds the DUT in reset for a fixed number of cycles, then applies `cycles` pseudo-random input vectors.
- Vectors come from the team-standard 32-bit LCG: state' = state*0x41C64E6D + 0x3039 mod 2^32.
- Compresses each DUT output into a MISR signature and flags `done`, enabling on-chip or emulator runs and cross-simulator signature comparison.

---
 rtl/fuzz_seq_pkg.sv | 20 ++
 rtl/fuzz_misr.sv | 45 ++++
 rtl/fuzz_stim_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fuzz_seq_pkg.sv
// Shared constants, FSM state type and LCG step for the fuzz stimulus sequencer.
package fuzz_seq_pkg;

  localparam logic [31:0] LCG_MUL      = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC      = 32'h0000_3039;
  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    INIT,
    RUN,
    DONE
  } seq_state_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] state);
    return state * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// XOR-folds a wide DUT output word into SIG_W bits and compresses it into a MISR.
module fuzz_misr
  import fuzz_seq_pkg::*;
#(
  parameter int                 SIG_W = 32,
  parameter int                 OUT_W = 330,
  parameter logic [SIG_W-1:0]   POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_data,
  output logic [SIG_W-1:0] o_sig
);

  localparam int NCH = (OUT_W + SIG_W - 1) / SIG_W;

  logic [NCH*SIG_W-1:0] w_pad;
  logic [SIG_W-1:0]     w_fold;
  logic [SIG_W-1:0]     r_sig;

  // Top chunk is zero-padded so the fold is well defined for any OUT_W.
  assign w_pad = (NCH*SIG_W)'(i_data);

  always_comb begin
    w_fold = '0;
    for (int c = 0; c < NCH; c++) begin
      w_fold = w_fold ^ w_pad[c*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_fold;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// Resets a fuzz DUT, drives it with LCG vectors and signs its outputs with a MISR.
// Optional pause input is enabled by defining FUZZ_SEQ_PAUSE_EN.
module fuzz_stim_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int               IN_W       = 255,
  parameter int               OUT_W      = 330,
  parameter int               CNT_W      = 32,
  parameter int               RST_CYCLES = 2,
  parameter int               SIG_W      = 32,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef FUZZ_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  in_flat,
  input  logic [OUT_W-1:0] out_flat,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [SIG_W-1:0] signature,
  output seq_state_e       dbg_state
);

  localparam int NW     = (IN_W + 31) / 32;
  localparam int TOP_LO = (NW - 1) * 32;
  localparam int TOP_B  = IN_W - TOP_LO;
  localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

  seq_state_e       r_state;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_lcg;
  logic [IN_W-1:0]  r_shadow;
  logic [IN_W-1:0]  r_in_flat;
  logic [CNT_W-1:0] r_cyc_lim;
  logic [CNT_W-1:0] r_vec_count;
  logic             r_dut_rst_n;
  logic             r_busy;
  logic             r_done;

  logic             w_pause;
  logic             w_start_ok;
  logic             w_step;
  logic             w_last_word;
  logic             w_misr_en;
  logic [31:0]      w_lcg_next;
  logic [IN_W-1:0]  w_vec;
  logic [CNT_W-1:0] w_vec_inc;

`ifdef FUZZ_SEQ_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // start is a one-cycle request with no ready: it is accepted only in IDLE or
  // DONE and silently dropped while a run is in progress.
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_step      = ((r_state == INIT) || (r_state == RUN)) && !w_pause;
  assign w_last_word = (r_idx == IDX_LAST);
  assign w_misr_en   = w_step && (r_state == RUN) && w_last_word;
  assign w_lcg_next  = lcg_next(r_lcg);
  assign w_vec_inc   = r_vec_count + 1'b1;

  // The top word goes straight to in_flat on the final fill cycle.
  always_comb begin
    w_vec = r_shadow;
    w_vec[IN_W-1:TOP_LO] = w_lcg_next[TOP_B-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_idx       <= '0;
      r_lcg       <= '0;
      r_shadow    <= '0;
      r_in_flat   <= '0;
      r_cyc_lim   <= '0;
      r_vec_count <= '0;
      r_dut_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state     <= RESET;
            r_lcg       <= seed;
            r_cyc_lim   <= cycles;
            r_vec_count <= '0;
            r_rst_cnt   <= '0;
            r_idx       <= '0;
            r_dut_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        RESET: begin
          if (r_rst_cnt == RC_LAST) begin
            r_state <= INIT;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        INIT, RUN: begin
          r_dut_rst_n <= 1'b1;
          if (w_step) begin
            r_lcg <= w_lcg_next;
            for (int k = 0; k < NW - 1; k++) begin
              if (r_idx == IDX_W'(k)) r_shadow[k*32 +: 32] <= w_lcg_next;
            end
            if (w_last_word) begin
              r_idx     <= '0;
              r_in_flat <= w_vec;
              if (r_state == RUN) r_vec_count <= w_vec_inc;
              // INIT with a zero limit finishes without entering RUN.
              if (((r_state == INIT) && (r_cyc_lim == '0)) ||
                  ((r_state == RUN) && (w_vec_inc == r_cyc_lim))) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= RUN;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fuzz_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok),
    .i_en   (w_misr_en),
    .i_data (out_flat),
    .o_sig  (signature)
  );

  assign dut_rst_n = r_dut_rst_n;
  assign in_flat   = r_in_flat;
  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_count = r_vec_count;
  assign dbg_state = r_state;

endmodule
